// File: rtl/pc_lut_pkg.sv
// Shared sizing, FSM state and table-entry types for the branch-target
// table and its reverse-lookup engine.
package pc_lut_pkg;

    localparam int D_DEF  = 10;
    localparam int N_DEF  = 16;
    localparam int AW_DEF = $clog2(N_DEF);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    typedef struct packed {
        logic             valid;
        logic [D_DEF-1:0] target;
    } entry_t;

endpackage

// File: rtl/pc_lut_encoder_if.sv
// Programming, read and search signals of the branch-target table.
// The master side is the loader/requester and the slave side is the table.
interface pc_lut_encoder_if
    import pc_lut_pkg::*;
#(
    parameter int D  = D_DEF,
    parameter int N  = N_DEF,
    parameter int AW = $clog2(N)
);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [D-1:0]  wr_data;
    logic          clear_all;
    logic [AW-1:0] rd_addr;
    logic [D-1:0]  rd_target;
    logic          rd_valid;

    logic          search_req;
    logic [D-1:0]  search_target;
    logic          search_busy;
    logic          search_done;
    logic          search_hit;
    logic [AW-1:0] search_index;

    modport master (
        output wr_en, wr_addr, wr_data, clear_all, rd_addr,
        output search_req, search_target,
        input  rd_target, rd_valid,
        input  search_busy, search_done, search_hit, search_index
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, clear_all, rd_addr,
        input  search_req, search_target,
        output rd_target, rd_valid,
        output search_busy, search_done, search_hit, search_index
    );

endinterface

// File: rtl/pc_lut_store.sv
// Table storage: N targets plus valid bits, write/clear port and two
// combinational read ports (fetch-side rd_addr and the scanner's index).
module pc_lut_store
    import pc_lut_pkg::*;
#(
    parameter int D  = D_DEF,
    parameter int N  = N_DEF,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [D-1:0]  wr_data,
    input  logic          clear_all,
    input  logic [AW-1:0] rd_addr,
    output logic [D-1:0]  rd_target,
    output logic          rd_valid,
    input  logic [AW-1:0] scan_addr,
    output logic [D-1:0]  scan_target,
    output logic          scan_valid
);

    logic [N-1:0][D-1:0] data;
    logic [N-1:0]        valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (clear_all) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_addr] <= 1'b1;
        end
    end

    // Data needs no reset; a clear in the same cycle drops the write.
    always_ff @(posedge clk) begin
        if (wr_en && !clear_all) begin
            data[wr_addr] <= wr_data;
        end
    end

    assign rd_target   = data[rd_addr];
    assign rd_valid    = valid[rd_addr];
    assign scan_target = data[scan_addr];
    assign scan_valid  = valid[scan_addr];

endmodule

// File: rtl/pc_lut_encoder.sv
// Branch-target table with a sequential reverse lookup: one entry is
// compared per cycle, lowest index first, starting the cycle after accept.
module pc_lut_encoder
    import pc_lut_pkg::*;
#(
    parameter int D  = D_DEF,
    parameter int N  = N_DEF,
    parameter int AW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    pc_lut_encoder_if.slave bus
);

    state_t        state, state_d;
    logic [AW-1:0] idx;
    logic [D-1:0]  key;
    logic          hit;
    logic [AW-1:0] index;
    logic [D-1:0]  scan_target;
    logic          scan_valid;
    logic          match;
    logic          last;

    pc_lut_store #(.D(D), .N(N), .AW(AW)) u_store (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (bus.wr_en),
        .wr_addr     (bus.wr_addr),
        .wr_data     (bus.wr_data),
        .clear_all   (bus.clear_all),
        .rd_addr     (bus.rd_addr),
        .rd_target   (bus.rd_target),
        .rd_valid    (bus.rd_valid),
        .scan_addr   (idx),
        .scan_target (scan_target),
        .scan_valid  (scan_valid)
    );

    // The store is read before this edge's write lands, so a same-cycle
    // write to idx is compared with its old contents.
    assign match = scan_valid && (scan_target == key);
    assign last  = (idx == AW'(N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.search_req) state_d = SCAN;
            SCAN:    if (match || last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx   <= '0;
            key   <= '0;
            hit   <= 1'b0;
            index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.search_req) begin
                        key <= bus.search_target;
                        idx <= '0;
                    end
                end
                SCAN: begin
                    if (match) begin
                        hit   <= 1'b1;
                        index <= idx;
                    end else if (last) begin
                        hit   <= 1'b0;
                        index <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.search_busy  = (state != IDLE);
    assign bus.search_done  = (state == DONE);
    assign bus.search_hit   = hit;
    assign bus.search_index = index;

endmodule
